cpu_thread_sched: RTL

// - Round-robin thread scheduler for the sha512crypt CPU.
// - Decides which thread owns the CPU and sequences its context switch:

---
 rtl/cpu_thread_sched_if.sv | 28 ++
 rtl/cpu_thread_sched.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_thread_sched_if.sv
// Scheduler <-> CPU bundle: ready events, yield requests, and the per-thread
// state-memory controls (thread_num/load_en/save_en) plus run gating.
// master: CPU / event side. slave: the scheduler.
interface cpu_thread_sched_if #(
    parameter int unsigned N_THREADS = 4
);
    localparam int N_THREADS_MSB = $clog2(N_THREADS) - 1;

    logic [N_THREADS-1:0]   thread_ready_set;
    logic                   yield;
    logic                   yield_sleep;
    logic [N_THREADS_MSB:0] thread_num;
    logic                   load_en;
    logic                   save_en;
    logic                   run;
    logic [N_THREADS-1:0]   ready_mask;
    logic                   idle;

    modport master (
        output thread_ready_set, yield, yield_sleep,
        input  thread_num, load_en, save_en, run, ready_mask, idle
    );

    modport slave (
        input  thread_ready_set, yield, yield_sleep,
        output thread_num, load_en, save_en, run, ready_mask, idle
    );
endinterface

// File: rtl/cpu_thread_sched.sv
// Round-robin hardware-thread scheduler for the sha512crypt CPU.
// Sequences context switches as RUN -> SAVE (outgoing) -> LOAD (incoming) -> RUN.
// Optional feature: define THREAD_SCHED_QUANTUM_EN to preempt a thread after
// QUANTUM run cycles; without it a thread keeps the CPU until it yields.
module cpu_thread_sched #(
    parameter int unsigned N_THREADS = 4
`ifdef THREAD_SCHED_QUANTUM_EN
    ,
    parameter int unsigned QUANTUM   = 64
`endif
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    cpu_thread_sched_if.slave     bus
);
    localparam int N_THREADS_MSB = $clog2(N_THREADS) - 1;
`ifdef THREAD_SCHED_QUANTUM_EN
    localparam int QUANTUM_MSB   = $clog2(QUANTUM) - 1;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StSave} state_e;

    state_e                 state_q;
    logic [N_THREADS_MSB:0] thread_num_q;
    logic [N_THREADS_MSB:0] rr_last_q;
    logic [N_THREADS-1:0]   ready_q;
    logic [N_THREADS-1:0]   ready_d;
    logic [N_THREADS-1:0]   clr_mask;
    logic [N_THREADS_MSB:0] sel;
`ifdef THREAD_SCHED_QUANTUM_EN
    logic [QUANTUM_MSB:0]   qcnt_q;
`endif

    // First set bit of mask, scanning upward from last+1 and wrapping.
    function automatic logic [N_THREADS_MSB:0] rr_pick(
        input logic [N_THREADS-1:0]   mask,
        input logic [N_THREADS_MSB:0] last
    );
        logic [N_THREADS_MSB:0] pick;
        logic                   found;
        int unsigned            idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= N_THREADS; i++) begin
            idx = (32'(last) + i) % N_THREADS;
            if (!found && mask[idx]) begin
                pick  = idx[N_THREADS_MSB:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Ready-bit update (set beats sleep-clear) and round-robin pick from the registered mask.
    always_comb begin
        clr_mask = '0;
        if (state_q == StRun && bus.yield && bus.yield_sleep) begin
            clr_mask[thread_num_q] = 1'b1;
        end
        ready_d = (ready_q & ~clr_mask) | bus.thread_ready_set;
        sel     = rr_pick(ready_q, rr_last_q);
    end

    // Scheduler FSM with ready mask, owner and optional quantum counter.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            thread_num_q <= '0;
            rr_last_q    <= (N_THREADS_MSB + 1)'(N_THREADS - 1);
            ready_q      <= '0;
`ifdef THREAD_SCHED_QUANTUM_EN
            qcnt_q       <= '0;
`endif
        end else begin
            ready_q <= ready_d;
            unique case (state_q)
                StIdle: begin
                    if (|ready_q) begin
                        thread_num_q <= sel;
                        rr_last_q    <= sel;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= StRun;
`ifdef THREAD_SCHED_QUANTUM_EN
                    qcnt_q  <= '0;
`endif
                end
                StRun: begin
                    if (bus.yield) begin
                        state_q <= StSave;
`ifdef THREAD_SCHED_QUANTUM_EN
                    end else if (qcnt_q == (QUANTUM_MSB + 1)'(QUANTUM - 1)) begin
                        state_q <= StSave;
                    end else begin
                        qcnt_q  <= qcnt_q + 1'b1;
`endif
                    end
                end
                StSave: begin
                    // ready_q already reflects the sleep clear applied on leaving RUN.
                    if (|ready_q) begin
                        thread_num_q <= sel;
                        rr_last_q    <= sel;
                        state_q      <= StLoad;
                    end else begin
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.thread_num = thread_num_q;
    assign bus.load_en    = (state_q == StLoad);
    assign bus.save_en    = (state_q == StSave);
    assign bus.run        = (state_q == StRun);
    assign bus.ready_mask = ready_q;
    assign bus.idle       = (state_q == StIdle) && (ready_q == '0);
endmodule
